// File: rtl/seq_isqrt_if.sv
// Handshake bundle for seq_isqrt: radicand in, root/remainder out, plus busy status.
interface seq_isqrt_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned N = WIDTH / 2;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] radicand;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     root;
  logic [N:0]       remainder;
  logic             busy;

  modport master (
    output in_valid, radicand, out_ready,
    input  in_ready, out_valid, root, remainder, busy
  );

  modport slave (
    input  in_valid, radicand, out_ready,
    output in_ready, out_valid, root, remainder, busy
  );
endinterface

// File: rtl/seq_isqrt.sv
// Iterative integer square root: one root bit per clock by restoring digit-by-digit
// subtraction. Floor root and remainder are held in output registers until consumed.
module seq_isqrt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  seq_isqrt_if.slave bus
);
  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [N+1:0]     rem_q;
  logic [N-1:0]     q_q;
  logic [CntW-1:0]  cnt_q;
  logic [N-1:0]     root_q;
  logic [N:0]       remainder_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [N+1:0]     rem_shift;
  logic [N+1:0]     trial;
  logic [N+1:0]     rem_next;
  logic [N-1:0]     q_next;
  logic             fits;
  logic             accept;

  // Ready in DONE only when the consumer takes the result this cycle, so a new
  // operand can be accepted in the same edge the old result leaves.
  assign bus.in_ready  = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.root      = root_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = busy_q;

  // One restoring step: bring down the next two radicand bits and try 4q+1.
  always_comb begin
    rem_shift = (rem_q << 2) | (N + 2)'(x_q[WIDTH-1 -: 2]);
    trial     = {q_q, 2'b01};
    fits      = (rem_shift >= trial);
    rem_next  = fits ? (rem_shift - trial) : rem_shift;
    q_next    = {q_q[N-2:0], fits};
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      root_q      <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            x_q     <= bus.radicand;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          x_q   <= x_q << 2;
          rem_q <= rem_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // Bit N+1 of the final remainder is always zero.
            root_q      <= q_next;
            remainder_q <= rem_next[N:0];
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              x_q     <= bus.radicand;
              rem_q   <= '0;
              q_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StCalc;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_isqrt.sv
// Self-checking bench for seq_isqrt at WIDTH=8 and WIDTH=16 against an arithmetic
// floor-sqrt reference.
module tb_seq_isqrt;
  logic clk = 1'b0;
  logic rst8;
  logic rst16;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_isqrt_if #(.WIDTH(8))  b8  ();
  seq_isqrt_if #(.WIDTH(16)) b16 ();

  seq_isqrt #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (b8)
  );

  seq_isqrt #(.WIDTH(16)) u_dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (b16)
  );

  // Largest r with r*r <= x.
  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until out_valid; n counts edges from the caller's point (accept is edge 1).
  task automatic wait8(output int n);
    n = 0;
    do begin
      step();
      n++;
      b8.in_valid = 1'b0;
    end while (!b8.out_valid && n < 40);
    if (!b8.out_valid) check("timeout8", b8.out_valid, 1);
  endtask

  task automatic wait16(input bit keep, output int n);
    n = 0;
    do begin
      step();
      n++;
      if (!keep) b16.in_valid = 1'b0;
    end while (!b16.out_valid && n < 40);
    if (!b16.out_valid) check("timeout16", b16.out_valid, 1);
  endtask

  task automatic run8(input int x, output int r, output int m, output int n);
    b8.radicand  = 8'(x);
    b8.in_valid  = 1'b1;
    b8.out_ready = 1'b1;
    wait8(n);
    r = int'(b8.root);
    m = int'(b8.remainder);
    step();
  endtask

  initial begin
    int r;
    int m;
    int n;
    int x;
    int hits;
    int stall;

    rst8 = 1'b1;
    rst16 = 1'b1;
    b8.in_valid = 1'b0;
    b8.radicand = '0;
    b8.out_ready = 1'b0;
    b16.in_valid = 1'b0;
    b16.radicand = '0;
    b16.out_ready = 1'b0;
    step();
    step();
    rst8 = 1'b0;
    rst16 = 1'b0;

    check("rst_out_valid", b8.out_valid, 0);
    check("rst_busy", b8.busy, 0);
    check("rst_in_ready", b8.in_ready, 1);
    check("rst_root", b8.root, 0);
    check("rst_rem", b8.remainder, 0);
    check("rst16_in_ready", b16.in_ready, 1);

    // Max 8-bit input, latency N after accept.
    run8(255, r, m, n);
    check("lat255", n, 5);
    check("root255", r, 15);
    check("rem255", m, 30);

    // Exhaustive 8-bit sweep.
    for (int v = 0; v < 256; v++) begin
      run8(v, r, m, n);
      check("sweep_root", r, ref_root(v));
      check("sweep_rem", m, v - ref_root(v) * ref_root(v));
      check("sweep_sum", r * r + m, v);
      check("sweep_bound", (m <= 2 * r), 1);
      if (v == 0)  begin check("spot0_root", r, 0);  check("spot0_rem", m, 0); end
      if (v == 15) begin check("spot15_root", r, 3); check("spot15_rem", m, 6); end
      if (v == 16) begin check("spot16_root", r, 4); check("spot16_rem", m, 0); end
    end

    // Random-order 8-bit values.
    for (int i = 0; i < 30; i++) begin
      x = int'($urandom_range(255));
      run8(x, r, m, n);
      check("rnd8_root", r, ref_root(x));
      check("rnd8_rem", m, x - ref_root(x) * ref_root(x));
      check("rnd8_lat", n, 5);
    end

    // Reset in the middle of a calculation aborts it.
    b8.radicand = 8'd100;
    b8.in_valid = 1'b1;
    b8.out_ready = 1'b1;
    step();
    b8.in_valid = 1'b0;
    step();
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    check("abort_out_valid", b8.out_valid, 0);
    check("abort_busy", b8.busy, 0);
    check("abort_in_ready", b8.in_ready, 1);
    check("abort_root", b8.root, 0);
    check("abort_rem", b8.remainder, 0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b8.out_valid) hits++;
    end
    check("abort_no_result", hits, 0);
    run8(144, r, m, n);
    check("root144", r, 12);
    check("rem144", m, 0);

    // Operand changes and in_valid pulses during CALC are ignored.
    b8.radicand = 8'd81;
    b8.in_valid = 1'b1;
    b8.out_ready = 1'b1;
    step();
    b8.in_valid = 1'b0;
    check("busy_calc", b8.busy, 1);
    check("in_ready_calc", b8.in_ready, 0);
    step();
    b8.radicand = 8'($urandom);
    b8.in_valid = 1'b1;
    step();
    b8.in_valid = 1'b0;
    b8.radicand = 8'($urandom);
    wait8(n);
    check("stable_root", b8.root, 9);
    check("stable_rem", b8.remainder, 0);
    step();

    // 16-bit: stall the first result, second operand waits.
    b16.radicand = 16'd65535;
    b16.in_valid = 1'b1;
    b16.out_ready = 1'b0;
    wait16(1'b0, n);
    check("lat65535", n, 9);
    b16.radicand = 16'd40000;
    b16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_root", b16.root, 255);
      check("stall_rem", b16.remainder, 510);
      check("stall_valid", b16.out_valid, 1);
      check("stall_in_ready", b16.in_ready, 0);
      step();
    end
    b16.out_ready = 1'b1;
    wait16(1'b0, n);
    check("lat40000", n, 9);
    check("root40000", b16.root, 200);
    check("rem40000", b16.remainder, 0);
    step();

    // Back-to-back with in_valid held high.
    b16.radicand = 16'd1;
    b16.in_valid = 1'b1;
    b16.out_ready = 1'b1;
    wait16(1'b1, n);
    check("b2b1_gap", n, 9);
    check("b2b1_root", b16.root, 1);
    check("b2b1_rem", b16.remainder, 0);
    check("b2b_done_ready", b16.in_ready, 1);
    b16.radicand = 16'd2;
    wait16(1'b1, n);
    check("b2b2_gap", n, 9);
    check("b2b2_root", b16.root, 1);
    check("b2b2_rem", b16.remainder, 1);
    b16.radicand = 16'd3;
    wait16(1'b1, n);
    check("b2b3_gap", n, 9);
    check("b2b3_root", b16.root, 1);
    check("b2b3_rem", b16.remainder, 2);
    b16.in_valid = 1'b0;
    step();
    check("b2b_idle_valid", b16.out_valid, 0);

    // Random 16-bit operands with random stalls.
    for (int i = 0; i < 20; i++) begin
      x = int'($urandom_range(65535));
      stall = int'($urandom_range(3));
      b16.radicand = 16'(x);
      b16.in_valid = 1'b1;
      b16.out_ready = 1'b0;
      wait16(1'b0, n);
      check("rnd16_lat", n, 9);
      for (int s = 0; s < stall; s++) step();
      check("rnd16_root", b16.root, ref_root(x));
      check("rnd16_rem", b16.remainder, x - ref_root(x) * ref_root(x));
      b16.out_ready = 1'b1;
      step();
      check("rnd16_drop", b16.out_valid, 0);
      b16.out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
